// File: rtl/led_pattern_gen.sv
// led_pattern_gen: stepped LED patterns (binary, scan, gray, blink) paced by a TICK_DIV prescaler.
// Define LED_PWM_EN to gate the pattern with an 8-bit brightness PWM; otherwise brightness is ignored.
module led_pattern_gen #(
    parameter int              NUM_LEDS = 8,
    parameter longint unsigned TICK_DIV = 64'd16777216
) (
    input  logic                sysclock,
    input  logic                reset,
    input  logic [1:0]          mode,
    input  logic [7:0]          brightness,
    output logic [NUM_LEDS-1:0] leds,
    output logic                tick
);
    localparam int            PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 64'd1);

    typedef enum logic {UP, DOWN} scan_t;

    logic [PW-1:0]       pre;
    logic                step;
    logic [1:0]          cur_mode;
    logic [NUM_LEDS-1:0] cnt, cnt_inc, cnt_n, pat, pat_n, shifted;
    scan_t               dir, dir_n;

    always_ff @(posedge sysclock) begin
        if (reset) begin
            pre      <= '0;
            tick     <= 1'b0;
            cur_mode <= 2'd0;
            cnt      <= '0;
            pat      <= '0;
            dir      <= UP;
        end else begin
            pre  <= step ? '0 : pre + 1'b1;
            tick <= step;
            if (step) begin
                cur_mode <= mode;
                cnt      <= cnt_n;
                pat      <= pat_n;
                dir      <= dir_n;
            end
        end
    end

    // A mode change costs one step: the new mode's entry value is shown instead of an advance.
    always_comb begin
        step    = pre == LAST;
        cnt_inc = cnt + 1'b1;
        shifted = (dir == UP) ? pat << 1 : pat >> 1;
        cnt_n   = cnt_inc;
        pat_n   = pat;
        dir_n   = dir;
        if (mode != cur_mode) begin
            cnt_n = '0;
            dir_n = UP;
            pat_n = (mode == 2'd3) ? '1 : (mode == 2'd1) ? NUM_LEDS'(1) : '0;
        end else if (cur_mode == 2'd1) begin
            cnt_n = cnt;
            if (NUM_LEDS > 1) begin
                pat_n = shifted;
                dir_n = (dir == UP) ? (shifted[NUM_LEDS-1] ? DOWN : UP) : (shifted[0] ? UP : DOWN);
            end
        end else begin
            pat_n = (cur_mode == 2'd3) ? ~pat : (cur_mode == 2'd2) ? cnt_inc ^ (cnt_inc >> 1) : cnt_inc;
        end
    end

`ifdef LED_PWM_EN
    logic [7:0] pwm_cnt;

    always_ff @(posedge sysclock) begin
        if (reset) begin
            pwm_cnt <= 8'd0;
            leds    <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            leds    <= pat & {NUM_LEDS{pwm_cnt < brightness}};
        end
    end
`else
    logic unused_brightness;

    assign unused_brightness = ^brightness;
    assign leds = pat;
`endif
endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8: LED output width; legal range 1..32.
REQ-002 SHALL have parameter TICK_DIV, default 16777216: sysclock cycles per pattern step; legal range 2..2^32.
REQ-003 SHALL have port sysclock, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port mode, input, 2: pattern select; 0 binary, 1 scan, 2 gray, 3 blink.
REQ-006 SHALL have port brightness, input, 8: PWM duty; used only when LED_PWM_EN is defined.
REQ-007 SHALL have port leds, output, NUM_LEDS: registered LED drive.
REQ-008 SHALL have port tick, output, 1: registered one-cycle pulse marking each pattern step.

Function
REQ-009 SHALL increment a prescaler every cycle, wrapping from TICK_DIV-1 to 0; a step occurs on the edge where the prescaler wraps.
REQ-010 SHALL assert tick high for exactly the one cycle following each step edge; first tick is high TICK_DIV cycles after reset deasserts.
REQ-011 SHALL sample mode only on step edges; between steps, mode changes have no effect.
REQ-012 SHALL, when the sampled mode differs from the current mode, load that mode's entry value on the step instead of advancing: binary 0, scan 1 with direction UP, gray 0, blink all ones.
REQ-013 SHALL in binary mode advance an NUM_LEDS-bit counter by 1 per step, wrapping all-ones to 0; leds = counter.
REQ-014 SHALL in gray mode advance the same counter; leds = counter XOR (counter >> 1).
REQ-015 SHALL in scan mode run FSM {UP, DOWN}: UP shifts one-hot left; on reaching MSB, switches to DOWN. DOWN shifts right; on reaching LSB, switches to UP. The end LED is shown once per bounce.
REQ-016 SHALL hold scan at constant 1 when NUM_LEDS = 1.
REQ-017 SHALL in blink mode toggle leds between all ones and all zeros each step.
REQ-018 SHALL, without LED_PWM_EN, update leds on the step edge, coincident with tick rising.

Reset
REQ-019 SHALL on reset: prescaler 0, current mode 0, counter 0, scan state UP, leds 0, tick 0, PWM counter 0.
REQ-020 SHALL give reset priority over any step occurring on the same edge.
REQ-021 SHALL let reset asserted mid-step restart the prescaler, so the next tick is TICK_DIV cycles after deassertion.

Configuration
REQ-022 SHALL, with macro LED_PWM_EN defined, run an 8-bit free-running PWM counter and drive leds = pattern AND (pwm_cnt < brightness), registered. leds then lag the pattern by one cycle; brightness 0 forces off; 255 gives 255/256 duty.
REQ-023 SHALL, without LED_PWM_EN, omit the PWM logic, keep the brightness port, and ignore it.

Verification (NUM_LEDS=4, TICK_DIV=4)
REQ-024 SHALL cover: reset, mode=0 held -> leds 1,2,3,...,15,0; each value lasts 4 cycles; tick high every 4th cycle.
REQ-025 SHALL cover: reset, mode=1 held -> first tick 0001, then 0010, 0100, 1000, 0100, 0010, 0001, 0010.
REQ-026 SHALL cover: reset, mode=2 held -> 0000, 0001, 0011, 0010, 0110, 0111.
REQ-027 SHALL cover: mode 0 running at leds=0101; mode switched to 3 between ticks -> no change until next tick, then 1111, 0000, 1111.
REQ-028 SHALL cover: reset pulsed one cycle mid-scan at 0100 -> leds 0000 and tick 0 next cycle; first tick 4 cycles after deassertion.
REQ-029 SHALL cover: LED_PWM_EN defined, mode=3 at 1111, brightness=64 -> each LED high exactly 64 of every 256 cycles; brightness=0 -> leds stay 0000.
